// File: rtl/spmc_pwm_capture_pkg.sv
// Shared register map, control bit positions and address decode for the
// SpartanMC PWM capture peripheral.
package spmc_pwm_capture_pkg;

  localparam int PERI_W = 18;

  localparam int CONTROL_ADR      = 0;
  localparam int HIGH_START_ADR   = 1;
  localparam int PERIOD_START_ADR = 2;
  localparam int REG_STRIDE       = 2;
  localparam int ALL_REGS         = 17;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_SW_RESET_BIT = 1;

  localparam int STAT_ENABLE_BIT   = 8;
  localparam int STAT_SW_RESET_BIT = 9;
  localparam int STAT_NCH_LSB      = 12;
  localparam int STAT_NCH_W        = 6;
  localparam int STAT_FLAGS_W      = 8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_CONTROL,
    REG_HIGH,
    REG_PERIOD
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] chan;
  } reg_sel_t;

  // Offsets beyond the populated channels, though reserved, decode as REG_NONE.
  function automatic reg_sel_t decode_offset(input logic [9:0] ofs, input int nch);
    reg_sel_t sel;
    sel.kind = REG_NONE;
    sel.chan = '0;
    if (ofs == 10'(CONTROL_ADR)) begin
      sel.kind = REG_CONTROL;
    end else if (ofs < 10'(ALL_REGS)) begin
      for (int k = 0; k < 8; k++) begin
        if (k < nch) begin
          if (ofs == 10'(HIGH_START_ADR + REG_STRIDE * k)) begin
            sel.kind = REG_HIGH;
            sel.chan = 3'(k);
          end
          if (ofs == 10'(PERIOD_START_ADR + REG_STRIDE * k)) begin
            sel.kind = REG_PERIOD;
            sel.chan = 3'(k);
          end
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pwm_capture_channel.sv
// One PWM capture channel: input synchronizer, edge detect, period/high-time
// counter, commit and stuck-line handling, and the value-changed strobe.
module pwm_capture_channel #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_peri,
  input  logic                 chan_clr,
  input  logic                 pwm_pin,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 value_changed
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_STUCK = CNT_MAX - CNT_ONE;

  logic                 sync_p0, sync_p1, sync_p2;
  logic                 rise, fall, stuck, commit;
  logic                 armed;
  logic [CNT_WIDTH-1:0] cnt, high_latch;
  logic [CNT_WIDTH-1:0] new_high, new_period;

  // Stage p0..p2: two synchronizer flops plus one delay flop for edge detect
  always_ff @(posedge clk_peri) begin
    if (chan_clr) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= pwm_pin;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise  = sync_p1 & ~sync_p2;
  assign fall  = ~sync_p1 & sync_p2;
  // The counter is about to saturate with no rising edge in sight.
  assign stuck = ~rise & (cnt == CNT_STUCK);

  always_comb begin
    commit     = 1'b0;
    new_high   = high_time;
    new_period = period;
    if (rise && armed) begin
      commit     = 1'b1;
      new_high   = high_latch;
      new_period = cnt;
    end else if (stuck) begin
      commit     = 1'b1;
      new_high   = sync_p1 ? CNT_MAX : '0;
      new_period = '0;
    end
  end

  // Stage p3: counter, armed bit, committed measurement and change strobe
  always_ff @(posedge clk_peri) begin
    if (chan_clr) begin
      cnt           <= '0;
      high_latch    <= '0;
      armed         <= 1'b0;
      high_time     <= '0;
      period        <= '0;
      value_changed <= 1'b0;
    end else begin
      if (rise) begin
        cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
      if (fall) begin
        high_latch <= cnt;
      end
      if (rise) begin
        armed <= 1'b1;
      end else if (stuck) begin
        armed <= 1'b0;
      end
      if (commit) begin
        high_time <= new_high;
        period    <= new_period;
      end
      value_changed <= commit && ({new_high, new_period} != {high_time, period});
    end
  end

endmodule

// File: rtl/spmc_pwm_capture.sv
// SpartanMC PWM capture peripheral: per-channel period/high-time measurement
// with a bus-readable register file and a shared change strobe.
module spmc_pwm_capture
  import spmc_pwm_capture_pkg::*;
#(
  parameter logic [9:0] BASE_ADR           = 10'h0,
  parameter int         NUMBER_OF_CHANNELS = 2,
  parameter int         CNT_WIDTH          = 16
) (
  input  logic                          clk_peri,
  input  logic                          reset,
  input  logic [PERI_W-1:0]             do_peri,
  output logic [PERI_W-1:0]             di_peri,
  input  logic [9:0]                    addr_peri,
  input  logic                          access_peri,
  input  logic                          wr_peri,
  input  logic [NUMBER_OF_CHANNELS-1:0] pwm_in,
  output logic                          pwm_value_changed
);

  logic                          enable, sw_reset, chan_clr;
  logic [NUMBER_OF_CHANNELS-1:0] flags, chan_chg;
  logic [CNT_WIDTH-1:0]          high_time [NUMBER_OF_CHANNELS];
  logic [CNT_WIDTH-1:0]          period    [NUMBER_OF_CHANNELS];
  logic [9:0]                    ofs;
  reg_sel_t                      sel;
  logic                          rd_stb, rd_ctrl, wr_ctrl;
  logic [PERI_W-1:0]             rd_data;
  logic                          do_peri_unused;

  assign ofs     = addr_peri - BASE_ADR;
  assign sel     = decode_offset(ofs, NUMBER_OF_CHANNELS);
  assign rd_stb  = access_peri & ~wr_peri & (sel.kind != REG_NONE);
  assign rd_ctrl = rd_stb & (sel.kind == REG_CONTROL);
  assign wr_ctrl = access_peri & wr_peri & (sel.kind == REG_CONTROL);

  assign chan_clr       = reset | sw_reset | ~enable;
  assign do_peri_unused = ^do_peri[PERI_W-1:2];

  for (genvar k = 0; k < NUMBER_OF_CHANNELS; k++) begin : g_chan
    pwm_capture_channel #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_chan (
      .clk_peri     (clk_peri),
      .chan_clr     (chan_clr),
      .pwm_pin      (pwm_in[k]),
      .high_time    (high_time[k]),
      .period       (period[k]),
      .value_changed(chan_chg[k])
    );
  end

  assign pwm_value_changed = |chan_chg;

  always_ff @(posedge clk_peri) begin
    if (reset) begin
      enable   <= 1'b0;
      sw_reset <= 1'b0;
    end else if (wr_ctrl) begin
      enable   <= do_peri[CTRL_ENABLE_BIT];
      sw_reset <= do_peri[CTRL_SW_RESET_BIT];
    end
  end

  // A new change beats a concurrent CONTROL read so no event is lost.
  always_ff @(posedge clk_peri) begin
    if (reset) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~{NUMBER_OF_CHANNELS{rd_ctrl}}) | chan_chg;
    end
  end

  always_comb begin
    rd_data = '0;
    case (sel.kind)
      REG_CONTROL: begin
        rd_data[STAT_NCH_LSB +: STAT_NCH_W] = STAT_NCH_W'(NUMBER_OF_CHANNELS);
        rd_data[STAT_SW_RESET_BIT]          = sw_reset;
        rd_data[STAT_ENABLE_BIT]            = enable;
        rd_data[STAT_FLAGS_W-1:0]           = STAT_FLAGS_W'(flags);
      end
      REG_HIGH: begin
        for (int k = 0; k < NUMBER_OF_CHANNELS; k++) begin
          if (sel.chan == 3'(k)) rd_data = PERI_W'(high_time[k]);
        end
      end
      REG_PERIOD: begin
        for (int k = 0; k < NUMBER_OF_CHANNELS; k++) begin
          if (sel.chan == 3'(k)) rd_data = PERI_W'(period[k]);
        end
      end
      default: rd_data = '0;
    endcase
  end

  // Registered read port: data only in the cycle after a mapped read access
  always_ff @(posedge clk_peri) begin
    if (reset) begin
      di_peri <= '0;
    end else begin
      di_peri <= rd_stb ? rd_data : '0;
    end
  end

endmodule
